// File: rtl/kbd_pkg.sv
// Shared constants, parser states, event record layout and the set-2 scancode-to-ASCII table
// for the PS/2 keyboard event queue.
package kbd_pkg;

  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_PAUSE  = 8'hE1;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_ALT    = 8'h11;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  // Bytes that follow E1 in the Pause sequence
  localparam logic [2:0] PAUSE_TAIL = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXTBRK,
    ST_SKIP
  } kbd_parse_state_t;

  typedef struct packed {
    logic [7:0] ascii;
    logic [3:0] mods;
    logic       brk;
    logic       ext;
    logic [7:0] code;
  } kbd_evt_t;

  localparam int unsigned EVT_W         = $bits(kbd_evt_t);
  localparam int unsigned EVT_CODE_LSB  = 0;
  localparam int unsigned EVT_EXT_BIT   = 8;
  localparam int unsigned EVT_BRK_BIT   = 9;
  localparam int unsigned EVT_MODS_LSB  = 10;
  localparam int unsigned EVT_ASCII_LSB = 14;

  // Alphabet position 1..26 of a letter key, 0 for anything else
  function automatic logic [4:0] kbd_letter_idx(input logic [7:0] code);
    logic [4:0] idx;
    idx = '0;
    case (code)
      8'h1C: idx = 5'd1;   8'h32: idx = 5'd2;   8'h21: idx = 5'd3;
      8'h23: idx = 5'd4;   8'h24: idx = 5'd5;   8'h2B: idx = 5'd6;
      8'h34: idx = 5'd7;   8'h33: idx = 5'd8;   8'h43: idx = 5'd9;
      8'h3B: idx = 5'd10;  8'h42: idx = 5'd11;  8'h4B: idx = 5'd12;
      8'h3A: idx = 5'd13;  8'h31: idx = 5'd14;  8'h44: idx = 5'd15;
      8'h4D: idx = 5'd16;  8'h15: idx = 5'd17;  8'h2D: idx = 5'd18;
      8'h1B: idx = 5'd19;  8'h2C: idx = 5'd20;  8'h3C: idx = 5'd21;
      8'h2A: idx = 5'd22;  8'h1D: idx = 5'd23;  8'h22: idx = 5'd24;
      8'h35: idx = 5'd25;  8'h1A: idx = 5'd26;
      default: idx = '0;
    endcase
    return idx;
  endfunction

  // upper selects letter case (shift^caps), shift selects symbol row, ctrl gives control codes
  function automatic logic [7:0] kbd_scan_ascii(input logic [7:0] code, input logic upper,
                                                input logic shift, input logic ctrl);
    logic [4:0] idx;
    logic [7:0] a;
    idx = kbd_letter_idx(code);
    a   = '0;
    if (idx != '0) begin
      if (ctrl) a = {3'b000, idx};
      else      a = (upper ? 8'h40 : 8'h60) + {3'b000, idx};
    end else begin
      case (code)
        8'h16: a = shift ? 8'h21 : 8'h31;
        8'h1E: a = shift ? 8'h40 : 8'h32;
        8'h26: a = shift ? 8'h23 : 8'h33;
        8'h25: a = shift ? 8'h24 : 8'h34;
        8'h2E: a = shift ? 8'h25 : 8'h35;
        8'h36: a = shift ? 8'h5E : 8'h36;
        8'h3D: a = shift ? 8'h26 : 8'h37;
        8'h3E: a = shift ? 8'h2A : 8'h38;
        8'h46: a = shift ? 8'h28 : 8'h39;
        8'h45: a = shift ? 8'h29 : 8'h30;
        8'h0E: a = shift ? 8'h7E : 8'h60;
        8'h4E: a = shift ? 8'h5F : 8'h2D;
        8'h55: a = shift ? 8'h2B : 8'h3D;
        8'h54: a = shift ? 8'h7B : 8'h5B;
        8'h5B: a = shift ? 8'h7D : 8'h5D;
        8'h5D: a = shift ? 8'h7C : 8'h5C;
        8'h4C: a = shift ? 8'h3A : 8'h3B;
        8'h52: a = shift ? 8'h22 : 8'h27;
        8'h41: a = shift ? 8'h3C : 8'h2C;
        8'h49: a = shift ? 8'h3E : 8'h2E;
        8'h4A: a = shift ? 8'h3F : 8'h2F;
        8'h29: a = 8'h20;
        8'h5A: a = 8'h0D;
        8'h66: a = 8'h08;
        8'h0D: a = 8'h09;
        8'h76: a = 8'h1B;
        default: a = '0;
      endcase
    end
    return a;
  endfunction

endpackage

// File: rtl/ps2_kbd_event_queue_if.sv
// Decoded keyboard event stream (valid/ready). master = event producer, slave = consumer.
interface ps2_kbd_event_queue_if;
  logic       valid;
  logic       ready;
  logic [7:0] code;
  logic       ext;
  logic       brk;
  logic [3:0] mods;
  logic [7:0] ascii;

  modport master (output valid, code, ext, brk, mods, ascii, input ready);
  modport slave  (input valid, code, ext, brk, mods, ascii, output ready);
endinterface

// File: rtl/kbd_evt_fifo.sv
// Generic synchronous FIFO, WIDTH x DEPTH (power of two), with simultaneous push/pop when full.
module kbd_evt_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     clrn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the push needs
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ps2_kbd_event_queue.sv
// PS/2 set-2 scancode parser with modifier tracking feeding a buffered event FIFO.
// Optional KBD_TYPEMATIC_FILTER_EN suppresses auto-repeat makes of the last pressed key.
module ps2_kbd_event_queue
  import kbd_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DROP_W     = 8
) (
  input  logic                          clk,
  input  logic                          clrn,
  input  logic                          in_valid,
  input  logic [7:0]                    in_data,
  output logic                          in_ready,
  ps2_kbd_event_queue_if.master         evt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [DROP_W-1:0]             drop_cnt,
  output logic                          caps_led
);

  kbd_parse_state_t state, state_nx;
  logic [2:0] skip_cnt, skip_nx;
  logic       emit, e_brk, e_ext;
  logic [7:0] e_code;
  logic       lshift, rshift, ctrl, alt, caps, caps_held;
  logic       lshift_nx, rshift_nx, ctrl_nx, alt_nx, caps_nx, caps_held_nx;
  logic       shift_nx;
  logic       push, drop;
  logic       fifo_empty, fifo_full;
  kbd_evt_t   evt_in, evt_head;

  assign in_ready = 1'b1;
  assign caps_led = caps;

  always_comb begin
    state_nx = state;
    skip_nx  = skip_cnt;
    emit     = 1'b0;
    e_brk    = 1'b0;
    e_ext    = 1'b0;
    e_code   = in_data;
    if (in_valid) begin
      case (state)
        ST_IDLE: begin
          if (in_data == SC_EXT)        state_nx = ST_EXT;
          else if (in_data == SC_BRK)   state_nx = ST_BRK;
          else if (in_data == SC_PAUSE) begin
            state_nx = ST_SKIP;
            skip_nx  = PAUSE_TAIL;
          end else emit = 1'b1;
        end
        ST_EXT: begin
          if (in_data == SC_BRK)        state_nx = ST_EXTBRK;
          else if (in_data != SC_EXT) begin
            emit     = 1'b1;
            e_ext    = 1'b1;
            state_nx = ST_IDLE;
          end
        end
        ST_BRK, ST_EXTBRK: begin
          state_nx = ST_IDLE;
          if (in_data != SC_EXT && in_data != SC_BRK && in_data != SC_PAUSE) begin
            emit  = 1'b1;
            e_brk = 1'b1;
            e_ext = (state == ST_EXTBRK);
          end
        end
        ST_SKIP: begin
          skip_nx = skip_cnt - 3'd1;
          if (skip_cnt == 3'd1) begin
            emit     = 1'b1;
            e_ext    = 1'b1;
            e_code   = SC_PAUSE;
            state_nx = ST_IDLE;
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    lshift_nx    = lshift;
    rshift_nx    = rshift;
    ctrl_nx      = ctrl;
    alt_nx       = alt;
    caps_nx      = caps;
    caps_held_nx = caps_held;
    if (emit) begin
      if (!e_ext && e_code == SC_LSHIFT) lshift_nx = !e_brk;
      if (!e_ext && e_code == SC_RSHIFT) rshift_nx = !e_brk;
      if (e_code == SC_CTRL)             ctrl_nx   = !e_brk;
      if (e_code == SC_ALT)              alt_nx    = !e_brk;
      if (!e_ext && e_code == SC_CAPS) begin
        caps_held_nx = !e_brk;
        if (!e_brk && !caps_held) caps_nx = !caps;
      end
    end
  end

  assign shift_nx     = lshift_nx | rshift_nx;
  assign evt_in.code  = e_code;
  assign evt_in.ext   = e_ext;
  assign evt_in.brk   = e_brk;
  assign evt_in.mods  = {caps_nx, alt_nx, ctrl_nx, shift_nx};
  assign evt_in.ascii = (e_brk || e_ext) ? '0
                        : kbd_scan_ascii(e_code, shift_nx ^ caps_nx, shift_nx, ctrl_nx);

`ifdef KBD_TYPEMATIC_FILTER_EN
  logic       last_vld;
  logic [8:0] last_key;
  logic       repeat_make;

  assign repeat_make = emit && !e_brk && last_vld && (last_key == {e_ext, e_code});
  assign push        = emit && !repeat_make;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      last_vld <= 1'b0;
      last_key <= '0;
    end else if (emit) begin
      if (!e_brk) begin
        last_vld <= 1'b1;
        last_key <= {e_ext, e_code};
      end else if (last_key == {e_ext, e_code}) begin
        last_vld <= 1'b0;
      end
    end
  end
`else
  assign push = emit;
`endif

  // Full implies non-empty, so a pop is possible exactly when ready is high
  assign drop = push && fifo_full && !evt.ready;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state     <= ST_IDLE;
      skip_cnt  <= '0;
      lshift    <= 1'b0;
      rshift    <= 1'b0;
      ctrl      <= 1'b0;
      alt       <= 1'b0;
      caps      <= 1'b0;
      caps_held <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      state     <= state_nx;
      skip_cnt  <= skip_nx;
      lshift    <= lshift_nx;
      rshift    <= rshift_nx;
      ctrl      <= ctrl_nx;
      alt       <= alt_nx;
      caps      <= caps_nx;
      caps_held <= caps_held_nx;
      if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  kbd_evt_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .clrn  (clrn),
    .push  (push),
    .wdata (evt_in),
    .pop   (evt.ready),
    .rdata (evt_head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  assign evt.valid = !fifo_empty;
  assign evt.code  = evt_head.code;
  assign evt.ext   = evt_head.ext;
  assign evt.brk   = evt_head.brk;
  assign evt.mods  = evt_head.mods;
  assign evt.ascii = evt_head.ascii;

endmodule

// File: tb/tb_ps2_kbd_event_queue.sv
// Self-checking bench: queue-based behavioural model of the keyboard event queue, compared every cycle.
module tb_ps2_kbd_event_queue;
  localparam int unsigned DEPTH = 16;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic [4:0] fifo_count;
  logic [7:0] drop_cnt;
  logic       caps_led;

  ps2_kbd_event_queue_if ev ();

  ps2_kbd_event_queue #(.FIFO_DEPTH(DEPTH), .DROP_W(8)) dut (
    .clk        (clk),
    .clrn       (clrn),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .evt        (ev),
    .fifo_count (fifo_count),
    .drop_cnt   (drop_cnt),
    .caps_led   (caps_led)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic [3:0] mods;
    logic [7:0] ascii;
  } mev_t;

  int errors = 0;
  int checks = 0;

  // Model state: expected queue contents plus keyboard state
  mev_t        q[$];
  int unsigned mdrop;
  bit          p_ext, p_brk;
  int          p_skip;
  bit          m_lsh, m_rsh, m_ctrl, m_alt, m_caps, m_caps_held;
  bit          m_last_vld;
  logic [8:0]  m_last;

  logic [7:0] letter_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] sym_sc [21] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45,
                              8'h0E, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C, 8'h52, 8'h41, 8'h49, 8'h4A};
  logic [7:0] sym_lo [21] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h30,
                              8'h60, 8'h2D, 8'h3D, 8'h5B, 8'h5D, 8'h5C, 8'h3B, 8'h27, 8'h2C, 8'h2E, 8'h2F};
  logic [7:0] sym_hi [21] = '{8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E, 8'h26, 8'h2A, 8'h28, 8'h29,
                              8'h7E, 8'h5F, 8'h2B, 8'h7B, 8'h7D, 8'h7C, 8'h3A, 8'h22, 8'h3C, 8'h3E, 8'h3F};
  logic [7:0] spc_sc  [5] = '{8'h29, 8'h5A, 8'h66, 8'h0D, 8'h76};
  logic [7:0] spc_val [5] = '{8'h20, 8'h0D, 8'h08, 8'h09, 8'h1B};

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [7:0] m_ascii(logic [7:0] c, bit shift, bit caps, bit ctrl);
    for (int i = 0; i < 26; i++)
      if (letter_sc[i] == c) return ctrl ? 8'(i + 1) : ((shift ^ caps) ? 8'(65 + i) : 8'(97 + i));
    for (int i = 0; i < 21; i++)
      if (sym_sc[i] == c) return shift ? sym_hi[i] : sym_lo[i];
    for (int i = 0; i < 5; i++)
      if (spc_sc[i] == c) return spc_val[i];
    return 8'h00;
  endfunction

  function automatic void m_reset();
    q.delete();
    mdrop = 0;
    p_ext = 0; p_brk = 0; p_skip = 0;
    m_lsh = 0; m_rsh = 0; m_ctrl = 0; m_alt = 0; m_caps = 0; m_caps_held = 0;
    m_last_vld = 0; m_last = '0;
  endfunction

  function automatic void m_emit(logic [7:0] c, bit ext, bit brk);
    mev_t e;
    bit   shift;
    bit   suppress;
    suppress = 0;
    if (c == 8'h14) m_ctrl = !brk;
    if (c == 8'h11) m_alt  = !brk;
    if (!ext && c == 8'h12) m_lsh = !brk;
    if (!ext && c == 8'h59) m_rsh = !brk;
    if (!ext && c == 8'h58) begin
      if (!brk && !m_caps_held) m_caps = !m_caps;
      m_caps_held = !brk;
    end
    shift   = m_lsh || m_rsh;
    e.code  = c;
    e.ext   = ext;
    e.brk   = brk;
    e.mods  = {m_caps, m_alt, m_ctrl, shift};
    e.ascii = (brk || ext) ? 8'h00 : m_ascii(c, shift, m_caps, m_ctrl);
`ifdef KBD_TYPEMATIC_FILTER_EN
    if (!brk) begin
      if (m_last_vld && m_last == {ext, c}) suppress = 1;
      m_last_vld = 1;
      m_last     = {ext, c};
    end else if (m_last_vld && m_last == {ext, c}) begin
      m_last_vld = 0;
    end
`endif
    if (!suppress) begin
      if (q.size() < DEPTH) q.push_back(e);
      else if (mdrop < 255) mdrop++;
    end
  endfunction

  function automatic void m_byte(logic [7:0] b);
    if (p_skip > 0) begin
      p_skip--;
      if (p_skip == 0) m_emit(8'hE1, 1, 0);
    end else if (p_brk) begin
      if (b != 8'hE0 && b != 8'hF0 && b != 8'hE1) m_emit(b, p_ext, 1);
      p_brk = 0; p_ext = 0;
    end else if (p_ext) begin
      if (b == 8'hF0) p_brk = 1;
      else if (b != 8'hE0) begin
        m_emit(b, 1, 0);
        p_ext = 0;
      end
    end else begin
      if (b == 8'hE0)      p_ext = 1;
      else if (b == 8'hF0) p_brk = 1;
      else if (b == 8'hE1) p_skip = 7;
      else                 m_emit(b, 0, 0);
    end
  endfunction

  always @(posedge clk or negedge clrn) begin
    if (!clrn) m_reset();
    else begin
      if (ev.ready && q.size() > 0) q.delete(0);
      if (in_valid) m_byte(in_data);
    end
  end

  always @(negedge clk) begin
    chk("in_ready",   32'(in_ready),   32'd1);
    chk("evt_valid",  32'(ev.valid),   32'(q.size() != 0));
    chk("fifo_count", 32'(fifo_count), 32'(q.size()));
    chk("drop_cnt",   32'(drop_cnt),   32'(mdrop));
    chk("caps_led",   32'(caps_led),   32'(m_caps));
    if (q.size() != 0) begin
      chk("evt_code",  32'(ev.code),  32'(q[0].code));
      chk("evt_ext",   32'(ev.ext),   32'(q[0].ext));
      chk("evt_break", 32'(ev.brk),   32'(q[0].brk));
      chk("evt_mods",  32'(ev.mods),  32'(q[0].mods));
      chk("evt_ascii", 32'(ev.ascii), 32'(q[0].ascii));
    end
  end

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic pop_one();
    ev.ready = 1'b1;
    @(posedge clk); #1;
    ev.ready = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    ev.ready = 1'b1;
    while (ev.valid && k < 64) begin
      @(posedge clk); #1;
      k++;
    end
    ev.ready = 1'b0;
    chk("drain_done", 32'(ev.valid), 32'd0);
  endtask

  initial begin
    ev.ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 clrn = 1'b1;
    chk("rst_valid", 32'(ev.valid),   32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_drop",  32'(drop_cnt),   32'd0);
    chk("rst_caps",  32'(caps_led),   32'd0);

    send(8'h1C); send(8'hF0); send(8'h1C);
    chk("t1_count",   32'(fifo_count), 32'd2);
    chk("t1_code",    32'(ev.code),    32'h1C);
    chk("t1_ascii",   32'(ev.ascii),   32'h61);
    chk("t1_mods",    32'(ev.mods),    32'h0);
    chk("t1_m_brk",   32'(q[1].brk),   32'd1);
    chk("t1_m_ascii", 32'(q[1].ascii), 32'h00);
    drain();

    send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
    chk("t2_count",   32'(fifo_count), 32'd4);
    chk("t2_m_ascii", 32'(q[1].ascii), 32'h41);
    chk("t2_m_last",  32'(q[3].mods),  32'h0);
    pop_one();
    chk("t2_ascii",   32'(ev.ascii),   32'h41);
    chk("t2_mods",    32'(ev.mods),    32'h1);
    drain();

    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    chk("t3_count", 32'(fifo_count), 32'd2);
    chk("t3_code",  32'(ev.code),    32'h75);
    chk("t3_ext",   32'(ev.ext),     32'd1);
    chk("t3_ascii", 32'(ev.ascii),   32'h00);
    drain();
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    chk("t3_pause_count", 32'(fifo_count), 32'd1);
    chk("t3_pause_code",  32'(ev.code),    32'hE1);
    chk("t3_pause_ext",   32'(ev.ext),     32'd1);
    chk("t3_pause_brk",   32'(ev.brk),     32'd0);
    drain();

    for (int i = 0; i < 19; i++) send(letter_sc[i]);
    chk("t4_count", 32'(fifo_count), 32'd16);
    chk("t4_drop",  32'(drop_cnt),   32'd3);
    chk("t4_head",  32'(ev.code),    32'h1C);
    ev.ready = 1'b1;
    send(letter_sc[19]);
    ev.ready = 1'b0;
    chk("t4_pp_count", 32'(fifo_count), 32'd16);
    chk("t4_pp_drop",  32'(drop_cnt),   32'd3);
    chk("t4_pp_head",  32'(ev.code),    32'h32);
    drain();

    send(8'h58);
    chk("t5_caps_on", 32'(caps_led), 32'd1);
    send(8'h58); send(8'hF0); send(8'h58);
    chk("t5_caps_held", 32'(caps_led), 32'd1);
`ifdef KBD_TYPEMATIC_FILTER_EN
    chk("t5_count", 32'(fifo_count), 32'd2);
`else
    chk("t5_count", 32'(fifo_count), 32'd3);
`endif
    drain();

    send(8'hE0); send(8'hF0);
    clrn = 1'b0;
    @(posedge clk); #1;
    clrn = 1'b1;
    chk("t6_rst_count", 32'(fifo_count), 32'd0);
    chk("t6_rst_caps",  32'(caps_led),   32'd0);
    send(8'h1C);
    chk("t6_count", 32'(fifo_count), 32'd1);
    chk("t6_code",  32'(ev.code),    32'h1C);
    chk("t6_ext",   32'(ev.ext),     32'd0);
    chk("t6_brk",   32'(ev.brk),     32'd0);
    drain();

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
